// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared constants for the data-memory arbiter slice
package dmem_pkg;
    localparam int DMEM_DEPTH      = 48;
    localparam int DMEM_WORD_BYTES = 4;
    localparam int PORT_PIPE       = 0;
    localparam int PORT_DMA        = 1;
endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// starve_counter: saturating count of consecutive denied cycles, clear has priority
module starve_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        sat   = cnt_q == WIDTH'(LIMIT);
        cnt_d = clr ? '0 : (inc && !sat) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port priority arbiter for the shared data memory, with a
// starvation guard for the DMA port and registered per-port read/error responses
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH        = DMEM_DEPTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    logic             sat, p1_wins, sel_we, in_range, access;
    logic [31:0]      sel_addr, sel_wdata;
    logic [1:0]       gnt, rvalid_d, rvalid_q, err_d, err_q;
    logic [1:0][31:0] rdata_d, rdata_q;

    starve_counter #(.WIDTH(4), .LIMIT(STARVE_LIMIT)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (p1_req && !gnt[PORT_DMA]),
        .clr (!p1_req || gnt[PORT_DMA]),
        .sat (sat)
    );

    // Port 0 wins unless port 1 has waited long enough or port 0 is idle
    always_comb begin
        p1_wins         = p1_req && (sat || !p0_req);
        gnt[PORT_DMA]   = !rst && p1_wins;
        gnt[PORT_PIPE]  = !rst && p0_req && !p1_wins;
        sel_we          = gnt[PORT_DMA] ? p1_we    : p0_we;
        sel_addr        = gnt[PORT_DMA] ? p1_addr  : p0_addr;
        sel_wdata       = gnt[PORT_DMA] ? p1_wdata : p0_wdata;
        in_range        = sel_addr <= 32'(DEPTH - DMEM_WORD_BYTES);
        access          = |gnt && in_range;
        mem_addr        = access ? sel_addr  : '0;
        mem_wdata       = access ? sel_wdata : '0;
        mem_read        = access && !sel_we;
        mem_write       = access && sel_we;
    end

    // Out-of-range reads still complete, returning zero alongside err
    always_comb begin
        rvalid_d = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        for (int i = 0; i < 2; i++) begin
            rvalid_d[i] = gnt[i] && !sel_we;
            err_d[i]    = gnt[i] && !in_range;
            rdata_d[i]  = rvalid_d[i] ? (in_range ? mem_rdata : '0) : rdata_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Responses are masked while reset is held so an in-flight read never surfaces
    always_comb begin
        p0_gnt    = gnt[PORT_PIPE];
        p1_gnt    = gnt[PORT_DMA];
        p0_rvalid = !rst && rvalid_q[PORT_PIPE];
        p1_rvalid = !rst && rvalid_q[PORT_DMA];
        p0_err    = !rst && err_q[PORT_PIPE];
        p1_err    = !rst && err_q[PORT_DMA];
        p0_rdata  = rst ? '0 : rdata_q[PORT_PIPE];
        p1_rdata  = rst ? '0 : rdata_q[PORT_DMA];
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// behavioural model holding a shadow byte memory and the port-1 wait count
module tb_dmem_arbiter;
    localparam int DEPTH = 48;
    localparam int LIMIT = 4;

    logic        clk = 0, rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [7:0]  env_mem [DEPTH];
    logic [7:0]  ref_mem [DEPTH];
    int          starve;
    logic [1:0]  exp_rv, exp_err;
    logic [31:0] exp_rd [2];
    logic        obs_g0, obs_g1;
    int          n_tests, n_fail;

    dmem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory environment: big-endian byte array, junk on the bus when not read
    always_comb begin
        mem_rdata = 32'hBAD0_BAD0;
        if (mem_read && mem_addr <= 32'(DEPTH - 4))
            mem_rdata = {env_mem[int'(mem_addr)], env_mem[int'(mem_addr) + 1],
                         env_mem[int'(mem_addr) + 2], env_mem[int'(mem_addr) + 3]};
    end

    always @(posedge clk)
        if (mem_write && mem_addr <= 32'(DEPTH - 4))
            for (int k = 0; k < 4; k++) env_mem[int'(mem_addr) + k] <= mem_wdata[31 - 8 * k -: 8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[int'(a)], ref_mem[int'(a) + 1], ref_mem[int'(a) + 2], ref_mem[int'(a) + 3]};
    endfunction

    // One cycle: inputs already driven after a negedge; check, advance model, cross posedge
    task automatic step();
        logic        e0, e1, we, ok;
        logic [31:0] a, wd;
        int          p;
        #1;
        e1 = !rst && p1_req && (starve == LIMIT || !p0_req);
        e0 = !rst && p0_req && !e1;
        p  = e1 ? 1 : 0;
        we = e1 ? p1_we : p0_we;
        a  = e1 ? p1_addr : p0_addr;
        wd = e1 ? p1_wdata : p0_wdata;
        ok = a <= 32'(DEPTH - 4);
        obs_g0 = p0_gnt;
        obs_g1 = p1_gnt;
        chk("p0_gnt", p0_gnt, e0);
        chk("p1_gnt", p1_gnt, e1);
        chk("mem_read", mem_read, (e0 || e1) && ok && !we);
        chk("mem_write", mem_write, (e0 || e1) && ok && we);
        chk("mem_addr", mem_addr, ((e0 || e1) && ok) ? a : 32'h0);
        chk("mem_wdata", mem_wdata, ((e0 || e1) && ok) ? wd : 32'h0);
        chk("p0_rvalid", p0_rvalid, !rst && exp_rv[0]);
        chk("p1_rvalid", p1_rvalid, !rst && exp_rv[1]);
        chk("p0_err", p0_err, !rst && exp_err[0]);
        chk("p1_err", p1_err, !rst && exp_err[1]);
        chk("p0_rdata", p0_rdata, rst ? 32'h0 : exp_rd[0]);
        chk("p1_rdata", p1_rdata, rst ? 32'h0 : exp_rd[1]);
        starve  = (rst || !p1_req || e1) ? 0 : (starve < LIMIT ? starve + 1 : starve);
        exp_rv  = '0;
        exp_err = '0;
        if (rst) begin
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else if (e0 || e1) begin
            if (!we) begin
                exp_rv[p] = 1'b1;
                exp_rd[p] = ok ? ref_word(a) : 32'h0;
            end
            exp_err[p] = !ok;
            if (we && ok)
                for (int k = 0; k < 4; k++) ref_mem[int'(a) + k] = wd[31 - 8 * k -: 8];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic new_req(output logic r, output logic we, output logic [31:0] a, output logic [31:0] wd);
        int s;
        r  = $urandom_range(0, 2) != 0;
        we = $urandom_range(0, 1) == 1;
        wd = $urandom;
        s  = $urandom_range(0, 9);
        a  = s < 7 ? 32'(4 * $urandom_range(0, DEPTH / 4 - 1)) :
             s == 7 ? 32'($urandom_range(0, DEPTH - 4)) :
             s == 8 ? 32'($urandom_range(DEPTH - 3, DEPTH + 12)) :
             ($urandom_range(0, 1) == 1 ? 32'hFFFF_FFFE : 32'($urandom));
    endtask

    task automatic set0(input logic r, input logic we, input logic [31:0] a, input logic [31:0] wd);
        p0_req = r; p0_we = we; p0_addr = a; p0_wdata = wd;
    endtask

    task automatic set1(input logic r, input logic we, input logic [31:0] a, input logic [31:0] wd);
        p1_req = r; p1_we = we; p1_addr = a; p1_wdata = wd;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        starve  = 0;
        exp_rv  = '0;
        exp_err = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        rst = 1;
        set0(1, 1, 0, 32'h1111_1111);
        set1(1, 1, 4, 32'h2222_2222);
        @(negedge clk);
        step();
        step();
        rst = 0;
        step();
        chk("first_gnt_p0", obs_g0, 1);
        // write then read back on port 0
        set1(0, 0, 0, 0);
        set0(1, 1, 8, 32'hDEAD_BEEF);
        step();
        set0(1, 0, 8, 0);
        step();
        chk("wr_rd_rdata", p0_rdata, 32'hDEAD_BEEF);
        chk("wr_rd_rvalid", p0_rvalid, 1);
        // continuous contention: port 1 every fifth cycle
        set0(1, 0, 0, 0);
        set1(1, 0, 4, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("starve_p1_gnt", obs_g1, (i % 5) == 4);
        end
        // out of range read and wrap-around write
        set0(0, 0, 0, 0);
        set1(1, 0, 45, 0);
        step();
        chk("oor_p1_err", p1_err, 1);
        chk("oor_p1_rvalid", p1_rvalid, 1);
        chk("oor_p1_rdata", p1_rdata, 0);
        set1(0, 0, 0, 0);
        set0(1, 1, 32'hFFFF_FFFE, 32'h1234_5678);
        step();
        chk("oor_p0_err", p0_err, 1);
        // last legal word
        set0(1, 1, 44, 32'h0102_0304);
        step();
        chk("bnd_p0_err", p0_err, 0);
        set0(1, 0, 44, 0);
        step();
        chk("bnd_p0_rdata", p0_rdata, 32'h0102_0304);
        // reset while a read response is pending
        set0(0, 0, 0, 0);
        set1(1, 0, 0, 0);
        step();
        set1(0, 0, 0, 0);
        rst = 1;
        #1 chk("rst_p1_rvalid", p1_rvalid, 0);
        step();
        rst = 0;
        set0(1, 0, 0, 0);
        set1(1, 0, 4, 0);
        for (int i = 0; i < 3; i++) step();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_p1_gnt", obs_g1, i == 4);
        end
        // randomized traffic, protocol-respecting: hold each request until granted
        obs_g0 = 1;
        obs_g1 = 1;
        for (int c = 0; c < 600; c++) begin
            if (!p0_req || obs_g0) new_req(p0_req, p0_we, p0_addr, p0_wdata);
            if (!p1_req || obs_g1) new_req(p1_req, p1_we, p1_addr, p1_wdata);
            rst = $urandom_range(0, 39) == 0;
            step();
        end
        rst = 0;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        step();
        for (int i = 0; i < DEPTH; i++) chk("mem_byte", 32'(env_mem[i]), 32'(ref_mem[i]));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
